alu_acc_datapath: RTL and testbench

- Accumulator-based 8-bit arithmetic/logic datapath for the uProcessor core.
- A combinational ALU combines the accumulator (A) with an operand R and the stored carry flag (CY).
- The result and carry-out are written back into the accumulator register and the carry register on the rising clock edge, each under its own clock enable.
- The instruction decoder drives `alu_code`, `r` and the enables.

---
 rtl/alu_acc_datapath_if.sv | 24 ++
 rtl/alu_acc_datapath.sv | 66 ++++++
 tb/tb_alu_acc_datapath.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_acc_datapath_if.sv
// Decoder-to-datapath bundle: opcode, operand and write enables out; register state and ALU result back.
// Latency: n/a (wires only). Backpressure: none, no handshake on this path.
interface alu_acc_datapath_if #(
    parameter int unsigned WIDTH = 8
);
    logic [2:0]       alu_code;
    logic [WIDTH-1:0] r;
    logic             a_ce;
    logic             cy_ce;
    logic [WIDTH-1:0] acc;
    logic             cy;
    logic [WIDTH-1:0] alu_out;
    logic             alu_co;

    modport master (
        output alu_code, r, a_ce, cy_ce,
        input  acc, cy, alu_out, alu_co
    );

    modport slave (
        input  alu_code, r, a_ce, cy_ce,
        output acc, cy, alu_out, alu_co
    );
endinterface

// File: rtl/alu_acc_datapath.sv
// Accumulator ALU datapath: combinational ALU on (acc, r, cy) written back into acc/cy under separate enables.
// Latency: alu_out/alu_co same cycle; acc/cy one clock after opcode/operand.
// Backpressure: none; a_ce/cy_ce alone decide whether each register captures.
module alu_acc_datapath #(
    parameter int unsigned        WIDTH   = 8,
    parameter logic [WIDTH-1:0]   ACC_RST = '0,
    parameter logic               CY_RST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  nReset,
    alu_acc_datapath_if.slave     bus
);

    typedef enum logic [2:0] {
        OP_LD  = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_NOT = 3'd6,
        OP_NOP = 3'd7
    } alu_op_e;

    logic [WIDTH-1:0] acc_q;
    logic             cy_q;
    logic [WIDTH:0]   alu_res;
    logic [WIDTH:0]   ci_ext;
    alu_op_e          op;

    assign op     = alu_op_e'(bus.alu_code);
    assign ci_ext = {{WIDTH{1'b0}}, cy_q};

    // Top bit carries Co; for SUB the WIDTH+1-bit difference goes negative
    // exactly when A < R + Ci, so its sign bit is the borrow.
    always_comb begin
        alu_res = {cy_q, acc_q};
        case (op)
            OP_LD:   alu_res = {cy_q, bus.r};
            OP_ADD:  alu_res = {1'b0, acc_q} + {1'b0, bus.r} + ci_ext;
            OP_SUB:  alu_res = {1'b0, acc_q} - {1'b0, bus.r} - ci_ext;
            OP_AND:  alu_res = {cy_q, acc_q & bus.r};
            OP_OR:   alu_res = {cy_q, acc_q | bus.r};
            OP_XOR:  alu_res = {cy_q, acc_q ^ bus.r};
            OP_NOT:  alu_res = {cy_q, ~acc_q};
            OP_NOP:  alu_res = {cy_q, acc_q};
            default: alu_res = {cy_q, acc_q};
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            acc_q <= ACC_RST;
            cy_q  <= CY_RST;
        end else begin
            if (bus.a_ce)  acc_q <= alu_res[WIDTH-1:0];
            if (bus.cy_ce) cy_q  <= alu_res[WIDTH];
        end
    end

    assign bus.acc     = acc_q;
    assign bus.cy      = cy_q;
    assign bus.alu_out = alu_res[WIDTH-1:0];
    assign bus.alu_co  = alu_res[WIDTH];

endmodule

// File: tb/tb_alu_acc_datapath.sv
// Bench for alu_acc_datapath: directed vector table, reset corner sequence, then random run against a reference model.
// Latency: checks comb outputs mid-cycle and registers 1 time unit after each rising edge.
// Backpressure: none.
module tb_alu_acc_datapath;

    logic clk;
    logic nReset;
    int   checks;
    int   failures;

    alu_acc_datapath_if #(.WIDTH(8)) bus ();

    alu_acc_datapath #(
        .WIDTH  (8),
        .ACC_RST(8'h00),
        .CY_RST (1'b0)
    ) dut (
        .clk   (clk),
        .nReset(nReset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic [7:0] r;
        logic       a_ce;
        logic       cy_ce;
        logic [7:0] exp_out;
        logic       exp_co;
        logic [7:0] exp_acc;
        logic       exp_cy;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input int code, input int r, input int a_ce, input int cy_ce,
                                input int e_out, input int e_co, input int e_acc, input int e_cy);
        vec_t v;
        v.code    = 3'(code);
        v.r       = 8'(r);
        v.a_ce    = 1'(a_ce);
        v.cy_ce   = 1'(cy_ce);
        v.exp_out = 8'(e_out);
        v.exp_co  = 1'(e_co);
        v.exp_acc = 8'(e_acc);
        v.exp_cy  = 1'(e_cy);
        return v;
    endfunction

    // Reference ALU from the opcode rules with plain integer arithmetic; returns {co, out}.
    function automatic logic [8:0] ref_alu(input int code, input int a, input int r, input int ci);
        int s;
        logic [8:0] res;
        case (code)
            0: res = {1'(ci), 8'(r)};
            1: begin s = a + r + ci; res = {1'(s > 255), 8'(s % 256)}; end
            2: begin s = a - r - ci; res = {1'(s < 0), 8'((s + 512) % 256)}; end
            3: res = {1'(ci), 8'(a & r)};
            4: res = {1'(ci), 8'(a | r)};
            5: res = {1'(ci), 8'(a ^ r)};
            6: res = {1'(ci), 8'(255 - a)};
            default: res = {1'(ci), 8'(a)};
        endcase
        return res;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] code, input logic [7:0] r, input logic a_ce, input logic cy_ce);
        bus.alu_code = code;
        bus.r        = r;
        bus.a_ce     = a_ce;
        bus.cy_ce    = cy_ce;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m_acc;
        int m_cy;
        logic [8:0] exp_res;

        checks   = 0;
        failures = 0;

        //               code r     a  c  out    co acc    cy
        vecs[0]  = mk(1, 4,    1, 1, 4,     0, 4,     0);
        vecs[1]  = mk(1, 4,    1, 1, 8,     0, 8,     0);
        vecs[2]  = mk(1, 4,    1, 1, 12,    0, 12,    0);
        vecs[3]  = mk(2, 4,    1, 1, 8,     0, 8,     0);
        vecs[4]  = mk(0, 4,    1, 1, 4,     0, 4,     0);
        vecs[5]  = mk(6, 10,   1, 1, 251,   0, 251,   0);
        vecs[6]  = mk(1, 10,   1, 1, 5,     1, 5,     1);
        vecs[7]  = mk(1, 10,   1, 1, 16,    0, 16,    0);
        vecs[8]  = mk(2, 10,   1, 1, 6,     0, 6,     0);
        vecs[9]  = mk(2, 10,   1, 1, 252,   1, 252,   1);
        vecs[10] = mk(2, 10,   1, 1, 241,   0, 241,   0);
        vecs[11] = mk(0, 'hF0, 1, 1, 'hF0,  0, 'hF0,  0);
        vecs[12] = mk(3, 'h3C, 1, 1, 'h30,  0, 'h30,  0);
        vecs[13] = mk(4, 'h0F, 1, 1, 'h3F,  0, 'h3F,  0);
        vecs[14] = mk(5, 'hFF, 1, 1, 'hC0,  0, 'hC0,  0);
        vecs[15] = mk(1, 'h40, 1, 1, 'h00,  1, 'h00,  1);
        vecs[16] = mk(0, 'hF0, 1, 1, 'hF0,  1, 'hF0,  1);
        vecs[17] = mk(3, 'h3C, 1, 1, 'h30,  1, 'h30,  1);
        vecs[18] = mk(4, 'h0F, 1, 1, 'h3F,  1, 'h3F,  1);
        vecs[19] = mk(5, 'hFF, 1, 1, 'hC0,  1, 'hC0,  1);
        vecs[20] = mk(7, 'h55, 1, 1, 'hC0,  1, 'hC0,  1);
        vecs[21] = mk(1, 7,    0, 1, 'hC8,  0, 'hC0,  0);
        vecs[22] = mk(1, 'h50, 1, 0, 'h10,  1, 'h10,  0);
        vecs[23] = mk(1, 'hFF, 0, 0, 'h0F,  1, 'h10,  0);
        vecs[24] = mk(1, 'hFF, 0, 1, 'h0F,  1, 'h10,  1);
        vecs[25] = mk(2, 'h11, 1, 1, 'hFE,  1, 'hFE,  1);

        nReset = 1'b0;
        drive(3'd1, 8'h55, 1'b1, 1'b1);
        #12;
        check("reset acc", int'(bus.acc), 0);
        check("reset cy",  int'(bus.cy),  0);
        nReset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].code, vecs[i].r, vecs[i].a_ce, vecs[i].cy_ce);
            #1;
            check($sformatf("vec%0d alu_out", i), int'(bus.alu_out), int'(vecs[i].exp_out));
            check($sformatf("vec%0d alu_co", i),  int'(bus.alu_co),  int'(vecs[i].exp_co));
            step();
            check($sformatf("vec%0d acc", i), int'(bus.acc), int'(vecs[i].exp_acc));
            check($sformatf("vec%0d cy", i),  int'(bus.cy),  int'(vecs[i].exp_cy));
        end

        // Async reset between edges with a pending ADD discards it and holds.
        drive(3'd0, 8'hAB, 1'b1, 1'b1);
        step();
        check("preload acc", int'(bus.acc), 'hAB);
        check("preload cy",  int'(bus.cy),  1);
        drive(3'd1, 8'h01, 1'b1, 1'b1);
        #2;
        nReset = 1'b0;
        #1;
        check("async rst acc", int'(bus.acc), 0);
        check("async rst cy",  int'(bus.cy),  0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rst hold%0d acc", k), int'(bus.acc), 0);
            check($sformatf("rst hold%0d cy", k),  int'(bus.cy),  0);
        end
        #2;
        nReset = 1'b1;
        step();
        check("post rst acc", int'(bus.acc), 1);
        check("post rst cy",  int'(bus.cy),  0);

        m_acc = 1;
        m_cy  = 0;
        for (int n = 0; n < 400; n++) begin
            drive(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 31) == 0) begin
                nReset = 1'b0;
                #1;
                m_acc = 0;
                m_cy  = 0;
                check($sformatf("rnd%0d rst acc", n), int'(bus.acc), 0);
                step();
                check($sformatf("rnd%0d rst hold cy", n), int'(bus.cy), 0);
                nReset = 1'b1;
                continue;
            end
            #1;
            exp_res = ref_alu(int'(bus.alu_code), m_acc, int'(bus.r), m_cy);
            check($sformatf("rnd%0d alu_out", n), int'(bus.alu_out), int'(exp_res[7:0]));
            check($sformatf("rnd%0d alu_co", n),  int'(bus.alu_co),  int'(exp_res[8]));
            if (bus.a_ce)  m_acc = int'(exp_res[7:0]);
            if (bus.cy_ce) m_cy  = int'(exp_res[8]);
            step();
            check($sformatf("rnd%0d acc", n), int'(bus.acc), m_acc);
            check($sformatf("rnd%0d cy", n),  int'(bus.cy),  m_cy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
